// File: rtl/screen_phase_pkg.sv
// Shared phase encoding and layer-enable map for screen_phase_ctrl.
// Defining SCREEN_PAUSE_EN widens phase_t by one bit to add the PAUSE state.
package screen_phase_pkg;

`ifdef SCREEN_PAUSE_EN
    localparam int unsigned PHASE_W = 3;
`else
    localparam int unsigned PHASE_W = 2;
`endif

    typedef enum logic [PHASE_W-1:0] {
        TITLE     = PHASE_W'(0),
        PLAY      = PHASE_W'(1),
        HIT_FLASH = PHASE_W'(2),
`ifdef SCREEN_PAUSE_EN
        GAME_OVER = PHASE_W'(3),
        PAUSE     = PHASE_W'(4)
`else
        GAME_OVER = PHASE_W'(3)
`endif
    } phase_t;

    // Bit positions inside layerEnable, highest mux priority first.
    localparam int unsigned L_SPACESHIP  = 7;
    localparam int unsigned L_MONSTER_HP = 6;
    localparam int unsigned L_HP         = 5;
    localparam int unsigned L_HP2        = 4;
    localparam int unsigned L_BANANA     = 3;
    localparam int unsigned L_PROJECTILE = 2;
    localparam int unsigned L_SHIELD     = 1;
    localparam int unsigned L_BG         = 0;

    localparam logic [7:0] LAYERS_ALL  = 8'hFF;
    localparam logic [7:0] LAYERS_BG   = 8'h01;
    localparam logic [7:0] LAYERS_NONE = 8'h00;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/screen_phase_ctrl_frame_down_counter.sv
// Frame-tick down counter: load a start value, decrement on tick, hold at zero.
module frame_down_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         tick,
    output logic         zero_c
);

    logic [W-1:0] value;

    // Load wins over tick so an entry cycle never also consumes a frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (tick && (value != '0)) begin
            value <= value - W'(1);
        end
    end

    assign zero_c = (value == '0);

endmodule

// File: rtl/screen_phase_ctrl.sv
// Game-phase sequencer TITLE -> PLAY -> HIT_FLASH -> GAME_OVER driving compositor layer enables.
// Optional SCREEN_PAUSE_EN adds a PAUSE state toggled by pauseKey edges.
module screen_phase_ctrl
    import screen_phase_pkg::*;
#(
    parameter int unsigned FLASH_FRAMES = 60,
    parameter int unsigned BLINK_FRAMES = 8,
    parameter int unsigned OVER_FRAMES  = 120
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               startKey,
    input  logic               playerHit,
    input  logic               playerDead,
    input  logic               monstersDead,
    input  logic               pauseKey,
    output logic [7:0]         layerEnable,
    output logic               gameOver,
    output logic               winFlag,
    output logic               newGame,
    output logic [PHASE_W-1:0] phase
);

    localparam int unsigned CNT_W = $clog2(max_u(FLASH_FRAMES, OVER_FRAMES) + 1);
    localparam int unsigned BLK_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_FLASH  = CNT_W'(FLASH_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_OVER   = CNT_W'(OVER_FRAMES - 1);
    localparam logic [BLK_W-1:0] BLK_RELOAD = BLK_W'(BLINK_FRAMES - 1);

    phase_t           state, state_nx;
    logic             start_s, start_q, start_edge;
    logic             dead;
    logic             blink, blink_nx;
    logic             win_nx, new_game_nx;
    logic [7:0]       layer_nx;
    logic             cnt_load, cnt_tick, cnt_zero;
    logic [CNT_W-1:0] cnt_value;
    logic             blk_load, blk_tick, blk_zero;

    assign start_edge = start_s & ~start_q;
    assign dead       = playerDead | monstersDead;
    assign phase      = state;

`ifdef SCREEN_PAUSE_EN
    logic   pause_s, pause_q, pause_edge;
    phase_t saved_state;
    assign pause_edge = pause_s & ~pause_q;
`else
    logic unused_pause;
    assign unused_pause = pauseKey;
`endif

    frame_down_counter #(.W(CNT_W)) u_cnt (
        .clk        (clk),
        .resetN     (resetN),
        .load       (cnt_load),
        .load_value (cnt_value),
        .tick       (cnt_tick),
        .zero_c     (cnt_zero)
    );

    frame_down_counter #(.W(BLK_W)) u_blk (
        .clk        (clk),
        .resetN     (resetN),
        .load       (blk_load),
        .load_value (BLK_RELOAD),
        .tick       (blk_tick),
        .zero_c     (blk_zero)
    );

    // Next-phase decision; priority is death > hit > frame tick.
    always_comb begin
        state_nx    = state;
        cnt_load    = 1'b0;
        cnt_value   = CNT_FLASH;
        cnt_tick    = 1'b0;
        blk_load    = 1'b0;
        blk_tick    = 1'b0;
        blink_nx    = blink;
        win_nx      = winFlag;
        new_game_nx = 1'b0;
        case (state)
            TITLE: begin
                if (start_edge) begin
                    state_nx    = PLAY;
                    new_game_nx = 1'b1;
                end
            end
            PLAY, HIT_FLASH: begin
                if (dead) begin
                    state_nx  = GAME_OVER;
                    cnt_load  = 1'b1;
                    cnt_value = CNT_OVER;
                    win_nx    = monstersDead & ~playerDead;
                end else if (state == PLAY) begin
                    if (playerHit) begin
                        state_nx = HIT_FLASH;
                        cnt_load = 1'b1;
                        blk_load = 1'b1;
                        blink_nx = 1'b0;
                    end
                end else begin
                    // A repeat hit restarts the flash but leaves the blink cadence alone.
                    if (playerHit) begin
                        cnt_load = 1'b1;
                    end else begin
                        cnt_tick = startOfFrame;
                        if (startOfFrame && cnt_zero) state_nx = PLAY;
                    end
                    if (startOfFrame) begin
                        if (blk_zero) begin
                            blk_load = 1'b1;
                            blink_nx = ~blink;
                        end else begin
                            blk_tick = 1'b1;
                        end
                    end
                end
            end
            GAME_OVER: begin
                cnt_tick = startOfFrame;
                if (start_edge && cnt_zero) begin
                    state_nx    = PLAY;
                    new_game_nx = 1'b1;
                end
            end
`ifdef SCREEN_PAUSE_EN
            PAUSE: begin
                if (pause_edge) state_nx = saved_state;
            end
`endif
        endcase

`ifdef SCREEN_PAUSE_EN
        // Entering PAUSE cancels everything else this cycle so counters freeze exactly.
        if ((state == PLAY || state == HIT_FLASH) && !dead && pause_edge) begin
            state_nx = PAUSE;
            cnt_load = 1'b0;
            cnt_tick = 1'b0;
            blk_load = 1'b0;
            blk_tick = 1'b0;
            blink_nx = blink;
        end
`endif

        case (state_nx)
            TITLE:     layer_nx = LAYERS_BG;
            PLAY:      layer_nx = LAYERS_ALL;
            HIT_FLASH: begin
                layer_nx              = LAYERS_ALL;
                layer_nx[L_SPACESHIP] = blink_nx;
            end
            GAME_OVER: layer_nx = LAYERS_NONE;
            default:   layer_nx = layerEnable;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= TITLE;
            layerEnable <= LAYERS_BG;
            gameOver    <= 1'b0;
            winFlag     <= 1'b0;
            newGame     <= 1'b0;
            blink       <= 1'b0;
            start_s     <= 1'b0;
            start_q     <= 1'b0;
`ifdef SCREEN_PAUSE_EN
            pause_s     <= 1'b0;
            pause_q     <= 1'b0;
            saved_state <= PLAY;
`endif
        end else begin
            state       <= state_nx;
            layerEnable <= layer_nx;
            gameOver    <= (state_nx == GAME_OVER);
            winFlag     <= win_nx;
            newGame     <= new_game_nx;
            blink       <= blink_nx;
            start_s     <= startKey;
            start_q     <= start_s;
`ifdef SCREEN_PAUSE_EN
            pause_s     <= pauseKey;
            pause_q     <= pause_s;
            if (state_nx == PAUSE && state != PAUSE) saved_state <= state;
`endif
        end
    end

endmodule

// File: tb/tb_screen_phase_ctrl.sv
// Scoreboard bench for screen_phase_ctrl with FLASH_FRAMES=4, BLINK_FRAMES=2, OVER_FRAMES=3.
module tb_screen_phase_ctrl;
    import screen_phase_pkg::*;

    logic               clk = 1'b0;
    logic               resetN;
    logic               startOfFrame, startKey, playerHit, playerDead, monstersDead, pauseKey;
    logic [7:0]         layerEnable;
    logic               gameOver, winFlag, newGame;
    logic [PHASE_W-1:0] phase;

    typedef struct {
        string       tag;
        int unsigned ph;
        logic [7:0]  le;
        logic        go;
        logic        win;
        logic        ng;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    screen_phase_ctrl #(
        .FLASH_FRAMES (4),
        .BLINK_FRAMES (2),
        .OVER_FRAMES  (3)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .startKey     (startKey),
        .playerHit    (playerHit),
        .playerDead   (playerDead),
        .monstersDead (monstersDead),
        .pauseKey     (pauseKey),
        .layerEnable  (layerEnable),
        .gameOver     (gameOver),
        .winFlag      (winFlag),
        .newGame      (newGame),
        .phase        (phase)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input string tag, input int unsigned ph, input logic [7:0] le,
                            input logic go, input logic win, input logic ng);
        exp_t e;
        e.tag = tag; e.ph = ph; e.le = le; e.go = go; e.win = win; e.ng = ng;
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq("scoreboard_empty", 32'(1), 32'(0));
        end else begin
            e = sb_q.pop_front();
            check_eq({e.tag, ".phase"},    32'(phase),       32'(e.ph));
            check_eq({e.tag, ".layers"},   32'(layerEnable), 32'(e.le));
            check_eq({e.tag, ".gameOver"}, 32'(gameOver),    32'(e.go));
            check_eq({e.tag, ".winFlag"},  32'(winFlag),     32'(e.win));
            check_eq({e.tag, ".newGame"},  32'(newGame),     32'(e.ng));
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1);
    end

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; startKey = 1'b0; playerHit = 1'b0;
        playerDead = 1'b0; monstersDead = 1'b0; pauseKey = 1'b0;
        step(2);
        push_exp("reset", 0, 8'h01, 0, 0, 0); pop_cmp();
        resetN = 1'b1;
        step();
        push_exp("title_idle", 0, 8'h01, 0, 0, 0); pop_cmp();

        // Start key: newGame two clocks after the key rises, one clock wide.
        startKey = 1'b1;
        push_exp("key_sync",  0, 8'h01, 0, 0, 0);
        push_exp("start",     1, 8'hFF, 0, 0, 1);
        push_exp("start_end", 1, 8'hFF, 0, 0, 0);
        step(); pop_cmp();
        step(); pop_cmp();
        step(); pop_cmp();

        // Hit flash: spaceship bit reads 0,0,1,1 across frames, then back to PLAY.
        playerHit = 1'b1;
        push_exp("hit_f0", 2, 8'h7F, 0, 0, 0);
        step(); playerHit = 1'b0; pop_cmp();
        push_exp("hit_f1", 2, 8'h7F, 0, 0, 0); frame(); pop_cmp();
        push_exp("hit_f2", 2, 8'hFF, 0, 0, 0); frame(); pop_cmp();
        push_exp("hit_f3", 2, 8'hFF, 0, 0, 0); frame(); pop_cmp();
        push_exp("hit_done", 1, 8'hFF, 0, 0, 0); frame(); pop_cmp();

        // Death and hit together: death wins, player loss.
        playerDead = 1'b1; playerHit = 1'b1;
        push_exp("dead_hit", 3, 8'h00, 1, 0, 0);
        step(); playerDead = 1'b0; playerHit = 1'b0; pop_cmp();
        startKey = 1'b0; step(2);
        frame(); frame();
        startKey = 1'b1;
        push_exp("restart_wait", 3, 8'h00, 1, 0, 0);
        push_exp("restart",      1, 8'hFF, 0, 0, 1);
        push_exp("restart_end",  1, 8'hFF, 0, 0, 0);
        step(); pop_cmp();
        step(); pop_cmp();
        step(); pop_cmp();

        // Monsters cleared: win, early start ignored, start accepted once hold expires.
        monstersDead = 1'b1;
        push_exp("win", 3, 8'h00, 1, 1, 0);
        step(); monstersDead = 1'b0; pop_cmp();
        frame();
        startKey = 1'b0; step(2);
        startKey = 1'b1;
        push_exp("early_start", 3, 8'h00, 1, 1, 0);
        step(3); pop_cmp();
        startKey = 1'b0;
        frame(); frame(); step();
        startKey = 1'b1;
        push_exp("late_start",     1, 8'hFF, 0, 1, 1);
        push_exp("late_start_end", 1, 8'hFF, 0, 1, 0);
        step(2); pop_cmp();
        step(); pop_cmp();

        // Asynchronous reset mid flash.
        playerHit = 1'b1;
        step(); playerHit = 1'b0;
        frame();
        startKey = 1'b0;
        #2 resetN = 1'b0;
        push_exp("async_reset", 0, 8'h01, 0, 0, 0);
        #1 pop_cmp();
        push_exp("reset_held", 0, 8'h01, 0, 0, 0);
        step(); pop_cmp();
        resetN = 1'b1;
        push_exp("reset_release", 0, 8'h01, 0, 0, 0);
        step(); pop_cmp();

`ifdef SCREEN_PAUSE_EN
        // Pause after two flash frames freezes the flash; two frames remain afterwards.
        startKey = 1'b1; step(3);
        playerHit = 1'b1; step(); playerHit = 1'b0;
        frame(); frame();
        pauseKey = 1'b1;
        push_exp("pause_enter", 4, 8'hFF, 0, 0, 0);
        step(2); pop_cmp();
        repeat (10) frame();
        push_exp("pause_hold", 4, 8'hFF, 0, 0, 0); pop_cmp();
        pauseKey = 1'b0; step();
        pauseKey = 1'b1;
        push_exp("unpause", 2, 8'hFF, 0, 0, 0);
        step(2); pop_cmp();
        push_exp("pause_f3", 2, 8'hFF, 0, 0, 0); frame(); pop_cmp();
        push_exp("pause_done", 1, 8'hFF, 0, 0, 0); frame(); pop_cmp();
`endif

        if (sb_q.size() != 0) check_eq("scoreboard_leftover", 32'(sb_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
